fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage; directly upstream of immediate padding and decode.
//  Holds the PC, issues 32-bit instruction-memory reads and buffers the returned words in a small FIFO.
//  Presents {instruction, pc} to decode with a valid/ready handshake.
//  Handles branch redirects by flushing the FIFO and discarding stale responses.
// PARAMETERS
//  RESET_PC    64'h0  PC loaded on reset; bits [1:0] must be 0
//  FIFO_DEPTH  2      fetch buffer entries; power of two, >=2
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  64  byte address, always 4-aligned
//  imem_rsp_valid  in   1   read data valid; in order, 1 per accepted request, >=1 cycle after it
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   branch/exception redirect, single-cycle pulse
//  redirect_pc     in   64  new PC; bits [1:0] ignored (forced 0)
//  inst_valid      out  1   inst_out/inst_pc valid
//  inst_ready      in   1   decode accepts word
//  inst_out        out  32  instruction word to decode/pad
//  inst_pc         out  64  address of inst_out
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=S_REQ, FIFO empty, all outputs 0 except imem_req_addr=RESET_PC.
//  At most one outstanding memory request.
//  Credit rule: request only if fifo_count < FIFO_DEPTH (an outstanding request always has a reserved slot).
//  FSM:
//   S_REQ:   req_valid = credit.
//            On req_valid & req_ready: pc += 4, ->S_WAIT.
//   S_WAIT:  On rsp_valid: push {data, pc_of_req}, ->S_REQ.
//            Zero-bubble re-request is not required: next request issues in S_REQ on the following cycle.
//   S_DRAIN: Stale request in flight. On rsp_valid: drop data, ->S_REQ.
//  Redirect, any state, takes effect at the edge:
//   pc <= {redirect_pc[63:2], 2'b00}; FIFO flushed.
//   S_REQ with handshake in the same cycle -> S_DRAIN; S_REQ without handshake -> stays S_REQ.
//   S_WAIT without rsp -> S_DRAIN; S_WAIT with rsp in the same cycle -> rsp dropped, ->S_REQ.
//   S_DRAIN -> S_DRAIN; with rsp in the same cycle -> ->S_REQ.
//  inst_valid = FIFO non-empty & ~redirect_valid; gated low combinationally during the redirect cycle.
//  Pop on inst_valid & inst_ready. Push and pop in the same cycle are allowed; count is unchanged.
//  FIFO output is registered storage; decode latency from rsp_valid to inst_valid is 1 cycle.
//  pc wraps modulo 2^64 silently.
//  imem_req_addr = pc; it is held stable while req_valid & ~req_ready.
//  Reset asserted mid-operation: all state cleared immediately. A response arriving after reset release
//   with no request issued since reset is dropped (tracked by the outstanding flag).
// CONFIGURATION
//  FETCH_STATS_EN defined: adds output ports
//   stat_fetched  out 32  saturating count of pushed words
//   stat_flushed  out 32  saturating count of redirects
//   Both reset to 0.
//  FETCH_STATS_EN undefined: ports and counters are absent; no other change.
// STRUCTURE
//  params.vh: FSM state encodings (S_REQ/S_WAIT/S_DRAIN, 2 bits), INST_W=32, ADDR_W=64, PC_STEP=4.
//  Sub-module fetch_fifo: synchronous FIFO, WIDTH=96 ({pc, inst}), DEPTH=FIFO_DEPTH.
//   Ports: push, pop, flush, count, full, empty; flush has priority over push.
// TESTING
//  1 Reset, req_ready=1, rsp 1 cycle later with words A,B,C; inst_ready=1
//    -> addrs 0x0,0x4,0x8; inst_out A,B,C with inst_pc 0x0,0x4,0x8 in order.
//  2 inst_ready=0
//    -> exactly FIFO_DEPTH(2) requests issued, then req_valid stays 0.
//    Raise ready -> one pop frees one credit -> next request at 0x8.
//  3 Redirect to 0x1003 while in S_WAIT; stale rsp 3 cycles later
//    -> stale data dropped; next req addr 0x1000; FIFO empty, inst_valid 0 meanwhile.
//  4 Redirect coincident with rsp_valid in S_WAIT
//    -> word dropped, ->S_REQ, next addr = redirect target.
//  5 req_ready=0 for 5 cycles -> req_addr stable, pc unchanged; rst_n low mid-S_WAIT
//    -> outputs 0, pc=RESET_PC; late rsp ignored.
//  6 FETCH_STATS_EN: after scenarios 1+3 -> stat_fetched=3, stat_flushed=1.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 64;
    localparam int FIFO_W = ADDR_W + INST_W;
    localparam int STAT_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    // One buffered fetch: address in the upper bits, word in the lower bits.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Memory request/response, redirect and decode handshake
//               bundle of the fetch stage. master = fetch unit side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO buffering fetched {pc, inst} entries.
//               Flush has priority over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = FIFO_W,
    parameter int DEPTH = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire logic                   flush,
    input  wire logic [WIDTH-1:0]       wdata,
    output logic      [WIDTH-1:0]       rdata,
    output logic      [$clog2(DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        do_push  = push & ~full & ~flush;
        do_pop   = pop & ~empty & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Holds the PC, issues one read at a
//               time, buffers returned words and hands {inst, pc} to decode.
//               Redirects flush the buffer and drain any stale response.
//               Optional macro FETCH_STATS_EN adds stat_fetched/stat_flushed.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 64'h0,
    parameter int                FIFO_DEPTH = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fetch_unit_if.master      bus
`ifdef FETCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_fetched,
    output logic [STAT_W-1:0] stat_flushed
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              req_valid_q, req_valid_d;
    logic [CNT_W-1:0]  fifo_count, count_next;
    logic              fifo_empty, unused_fifo_full;
    logic              push, pop, flush, req_fire;
    logic [ADDR_W-1:0] redirect_target;
    logic              unused_redirect_lsbs;
    fetch_entry_t      wr_entry, rd_entry;

    assign redirect_target      = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
    assign req_fire             = req_valid_q & bus.imem_req_ready;
    assign flush                = bus.redirect_valid;
    assign bus.inst_valid       = ~fifo_empty & ~bus.redirect_valid;
    assign pop                  = bus.inst_valid & bus.inst_ready;
    assign wr_entry             = '{pc: req_pc_q, inst: bus.imem_rsp_data};

    assign bus.imem_req_valid   = req_valid_q;
    assign bus.imem_req_addr    = pc_q;
    assign bus.inst_out         = rd_entry.inst;
    assign bus.inst_pc          = rd_entry.pc;

    fetch_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (fifo_count),
        .full  (unused_fifo_full),
        .empty (fifo_empty)
    );

    // Request/response sequencing; a redirect always overrides the next PC.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    pc_d     = pc_q + PC_STEP;
                    req_pc_d = pc_q;
                    state_d  = bus.redirect_valid ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    push    = ~bus.redirect_valid;
                    state_d = S_REQ;
                end else if (bus.redirect_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.imem_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        if (bus.redirect_valid) pc_d = redirect_target;
    end

    // Request valid is registered: next cycle requests only when idle and a
    // buffer slot will still be free after this cycle's push/pop/flush.
    always_comb begin
        count_next = fifo_count;
        if (flush)              count_next = '0;
        else if (push && !pop)  count_next = fifo_count + CNT_W'(1);
        else if (!push && pop)  count_next = fifo_count - CNT_W'(1);
        req_valid_d = (state_d == S_REQ) && (count_next < CNT_W'(FIFO_DEPTH));
    end

    // FSM, PC and request-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [STAT_W-1:0] fetched_q, fetched_d;
    logic [STAT_W-1:0] flushed_q, flushed_d;

    // Saturating counters of buffered words and redirects.
    always_comb begin
        fetched_d = push               ? sat_inc(fetched_q) : fetched_q;
        flushed_d = bus.redirect_valid ? sat_inc(flushed_q) : flushed_q;
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;
`endif

endmodule
`default_nettype wire
